mem_arbiter_ctrl: RTL

Parametrised successor to the single-fetch/single-data memory controller. Arbitrates NUM_PORTS requesters, such as IF, MEM, and a future icache refill, onto the byte-serial 8-bit RAM/IO bus. Supports 1/2/4-byte accesses, fixed-priority or round-robin arbitration, requester-side abort, and UART back-pressure. Sits between the pipeline stages and the cpu top-level memory pins.

---
 rtl/mem_arbiter_ctrl_if.sv | 28 ++
 rtl/mem_arbiter_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl_if.sv
// mem_arbiter_ctrl_if: requester channels plus byte-serial RAM/IO bus bundle
interface mem_arbiter_ctrl_if #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32
);
   logic                          rdy;
   logic [NUM_PORTS-1:0]          req;
   logic [NUM_PORTS-1:0]          wr;
   logic [2*NUM_PORTS-1:0]        size;
   logic [ADDR_W*NUM_PORTS-1:0]   addr;
   logic [32*NUM_PORTS-1:0]       wdata;
   logic [31:0]                   rdata;
   logic [NUM_PORTS-1:0]          done;
   logic                          busy;
   logic [7:0]                    mem_din;
   logic [7:0]                    mem_dout;
   logic [31:0]                   mem_a;
   logic                          mem_wr;
   logic                          io_buffer_full;
   modport master (
      output rdy, req, wr, size, addr, wdata, mem_din, io_buffer_full,
      input  rdata, done, busy, mem_dout, mem_a, mem_wr
   );
   modport slave (
      input  rdy, req, wr, size, addr, wdata, mem_din, io_buffer_full,
      output rdata, done, busy, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: arbitrates NUM_PORTS requesters onto a byte-serial 8-bit RAM/IO bus
module mem_arbiter_ctrl #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int RR_MODE   = 0
) (
   input logic               clk,
   input logic               rst,
   mem_arbiter_ctrl_if.slave bus
);
   localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   logic [1:0]           state_q, state_d, k_q, k_d, last_q, last_d, k_nx, size_g;
   logic [PW-1:0]        g_q, g_d, ptr_q, ptr_d, gnt;
   logic [ADDR_W-1:0]    mem_a_q, mem_a_d, addr_g;
   logic [31:0]          wdata_q, wdata_d, rdata_q, rdata_d, wdata_g;
   logic [7:0]           mem_dout_q, mem_dout_d;
   logic                 mem_wr_q, mem_wr_d, wr_g, found, busy, stall, abort, adv, fin, start;
   logic [NUM_PORTS-1:0] done_q, done_d, elig;
   // Pick the granted port: lowest index, or first eligible at/after the RR pointer
   always_comb begin
      int j;
      j     = 0;
      elig  = bus.req & ~done_q;
      found = 1'b0;
      gnt   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         j = RR_MODE != 0 ? (int'(ptr_q) + i) % NUM_PORTS : i;
         if (!found && elig[j]) begin
            found = 1'b1;
            gnt   = PW'(j);
         end
      end
   end
   assign addr_g  = bus.addr[int'(gnt)*ADDR_W +: ADDR_W];
   assign size_g  = bus.size[int'(gnt)*2 +: 2];
   assign wdata_g = bus.wdata[int'(gnt)*32 +: 32];
   assign wr_g    = bus.wr[gnt];
   assign busy    = state_q != IDLE;
   // UART full only blocks write bytes aimed at the IO window
   assign stall   = state_q == WRITE && mem_a_q[17:16] == 2'b11 && bus.io_buffer_full;
   assign abort   = busy && !bus.req[g_q];
   assign adv     = busy && !abort && !stall;
   assign fin     = adv && k_q == last_q;
   assign start   = !busy && found;
   assign k_nx    = k_q + 2'd1;
   // Next-state: grant from IDLE, walk bytes, finish or abandon on abort
   always_comb begin
      state_d    = start ? (wr_g ? WRITE : READ) : (abort || fin) ? IDLE : state_q;
      g_d        = start ? gnt : g_q;
      ptr_d      = start ? (gnt == PW'(NUM_PORTS - 1) ? '0 : gnt + 1'b1) : ptr_q;
      last_d     = start ? (size_g == 2'd0 ? 2'd0 : size_g == 2'd1 ? 2'd1 : 2'd3) : last_q;
      k_d        = start ? 2'd0 : (adv && !fin) ? k_nx : k_q;
      mem_a_d    = start ? addr_g : (adv && !fin) ? mem_a_q + 1'b1 : mem_a_q;
      wdata_d    = start ? (wr_g ? wdata_g : '0) : wdata_q;
      mem_dout_d = start ? (wr_g ? wdata_g[7:0] : 8'h00) : (adv && !fin) ? wdata_q[{k_nx, 3'b000} +: 8] : mem_dout_q;
      mem_wr_d   = start ? wr_g : (abort || fin) ? 1'b0 : mem_wr_q;
      done_d     = fin ? NUM_PORTS'(1) << g_q : '0;
      rdata_d    = start ? '0 : rdata_q;
      if (adv && state_q == READ) rdata_d[{k_q, 3'b000} +: 8] = bus.mem_din;
   end
   // State registers; rdy low freezes everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         g_q        <= '0;
         ptr_q      <= '0;
         last_q     <= 2'd0;
         k_q        <= 2'd0;
         mem_a_q    <= '0;
         wdata_q    <= '0;
         mem_dout_q <= 8'h00;
         mem_wr_q   <= 1'b0;
         done_q     <= '0;
         rdata_q    <= '0;
      end else if (bus.rdy) begin
         state_q    <= state_d;
         g_q        <= g_d;
         ptr_q      <= ptr_d;
         last_q     <= last_d;
         k_q        <= k_d;
         mem_a_q    <= mem_a_d;
         wdata_q    <= wdata_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
      end
   end
   assign bus.mem_a    = 32'(mem_a_q);
   assign bus.mem_dout = mem_dout_q;
   assign bus.mem_wr   = mem_wr_q && bus.rdy && !stall;
   assign bus.busy     = busy;
   assign bus.done     = done_q;
   assign bus.rdata    = rdata_q;
endmodule
